// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  // Memory-wait tracking states
  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } ctrl_state_e;

  // r0 is hardwired to zero and never carries a real dependency
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Which hazard class owns the pipeline controls this cycle
  typedef enum logic [1:0] {
    NONE    = 2'd0,
    MEM     = 2'd1,
    BRANCH  = 2'd2,
    LOADUSE = 2'd3
  } hz_cause_e;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: the ID instruction reads a register the load in EX writes.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  output logic       load_use
);

  logic rs_hit;
  logic rt_hit;

  // Operand match only counts when that operand is really read
  always_comb begin
    rs_hit   = id_uses_rs && (id_rs == ex_rd);
    rt_hit   = id_uses_rt && (id_rt == ex_rd);
    load_use = ex_memread && (ex_rd != REG_ZERO) && (rs_hit || rt_hit);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Memory waits freeze everything, taken branches flush IF/ID and ID/EX,
// load-use inserts one bubble. Enables and flushes are combinational.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             en_pc,
  output logic             en_ifid,
  output logic             en_idex,
  output logic             en_exmem,
  output logic             en_memwb,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int                WCNT_W  = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WCNT_W-1:0] TO_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  ctrl_state_e       state, state_nxt;
  logic [WCNT_W-1:0] wait_cnt;
  logic              load_use;
  logic              mem_stall;
  logic              timeout;
  hz_cause_e         cause;

  hazard_detect u_hazard_detect (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rs (id_uses_rs),
    .id_uses_rt (id_uses_rt),
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .load_use   (load_use)
  );

  // Hazard classification; a timed-out wait is treated as if memory answered
  always_comb begin
    mem_stall = mem_req && !mem_ready;
    timeout   = (state == MEM_WAIT) && mem_stall && (wait_cnt == TO_LAST);
    if (mem_stall && !timeout) cause = MEM;
    else if (branch_taken)     cause = BRANCH;
    else if (load_use)         cause = LOADUSE;
    else                       cause = NONE;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Next-state: enter wait on a memory stall, leave on ready, drop or timeout
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:      if (mem_stall) state_nxt = MEM_WAIT;
      MEM_WAIT: if (!mem_stall || timeout) state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  // Output decode; the flush overrides the enable on the same register
  always_comb begin
    en_pc      = 1'b1;
    en_ifid    = 1'b1;
    en_idex    = 1'b1;
    en_exmem   = 1'b1;
    en_memwb   = 1'b1;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    if (rst) begin
      {en_pc, en_ifid, en_idex, en_exmem, en_memwb} = 5'b00000;
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else begin
      case (cause)
        MEM: {en_pc, en_ifid, en_idex, en_exmem, en_memwb} = 5'b00000;
        BRANCH: begin
          flush_ifid = 1'b1;
          flush_idex = 1'b1;
        end
        LOADUSE: begin
          en_pc      = 1'b0;
          en_ifid    = 1'b0;
          flush_idex = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Wait counter counts stalled memory cycles, including the one entering the wait
  always_ff @(posedge clk) begin
    if (rst)                        wait_cnt <= '0;
    else if (state_nxt == MEM_WAIT) wait_cnt <= wait_cnt + 1'b1;
    else                            wait_cnt <= '0;
  end

  // Timeout pulse and saturating stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      mem_err <= timeout;
      if (!en_pc && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline.
- Drives the enable inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and the flush (bubble-insert) controls for IF/ID and ID/EX.
- Resolves three hazard classes: load-use data hazards, taken-branch control hazards, and multi-cycle data-memory waits.
- Memory-wait tracking is a small FSM with a timeout; a stall performance counter is kept alongside.

Parameters:
MEM_TIMEOUT, 64, max consecutive MEM_WAIT cycles before forced release (>=2)
CNT_W, 32, width of stall performance counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
ex_memread  in  1  instruction in EX is a load
ex_rd  in  5  destination register of EX instruction
branch_taken  in  1  EX resolved a taken branch/jump this cycle
mem_req  in  1  MEM stage is issuing a data-memory access
mem_ready  in  1  data memory completes access this cycle
en_pc  out  1  PC update enable
en_ifid  out  1  IF/ID en_reg
en_idex  out  1  ID/EX en_reg
en_exmem  out  1  EX/MEM en_reg
en_memwb  out  1  MEM/WB en_reg
flush_ifid  out  1  load NOP into IF/ID at next edge
flush_idex  out  1  load bubble (all ctrl 0) into ID/EX at next edge
mem_err  out  1  one-cycle pulse: memory wait timed out
stall_cnt  out  CNT_W  cycles with en_pc low since reset, saturating

Behaviour:
- FSM states: RUN, MEM_WAIT. Registered state, wait counter (log2 MEM_TIMEOUT + 1 bits), stall_cnt, mem_err. All enable and flush outputs are combinational from state and inputs, so a stall takes effect in the same cycle.
- Reset: state=RUN, wait counter=0, stall_cnt=0, mem_err=0. While rst=1: all en_*=0, flush_*=1, regardless of other inputs.
- Memory stall (highest priority):
  - Condition: mem_req & ~mem_ready, in RUN or MEM_WAIT.
  - Outputs: all five en_*=0, flushes=0. The whole pipeline freezes; WB re-writes the same instruction, which is idempotent.
  - RUN->MEM_WAIT on that condition. MEM_WAIT->RUN when mem_ready=1, or when mem_req drops.
  - In the release cycle, outputs follow normal RUN evaluation.
- Timeout:
  - Wait counter increments each MEM_WAIT cycle.
  - When it reaches MEM_TIMEOUT-1 while still waiting: next edge returns to RUN, mem_err=1 for one cycle, counter clears.
  - In the timeout cycle, enables are forced as if mem_ready=1.
- Branch (priority 2), when no memory stall:
  - branch_taken=1 -> flush_ifid=1, flush_idex=1, all en_*=1.
  - The load-use condition is ignored in that cycle, because its instruction is being flushed.
- Load-use (priority 3):
  - Condition: ex_memread & (ex_rd!=0) & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
  - Outputs: en_pc=0, en_ifid=0, flush_idex=1, en_idex=en_exmem=en_memwb=1, flush_ifid=0.
  - Lasts exactly one cycle: after the bubble, the load has left EX.
- Otherwise: all en_*=1, flushes=0.
- flush_* and en_* for the same register: the flush wins. The ID/EX register clears when flush_idex=1 even if en_idex=1.
- stall_cnt: increments on every non-reset cycle with en_pc=0, including memory and load-use stalls. Holds at all-ones.
- ex_rd=0 never causes a stall (r0 hardwired).

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - FSM state encoding (RUN=1'b0, MEM_WAIT=1'b1).
  - Constant REG_ZERO=5'd0.
  - A hazard-cause enum (NONE, MEM, BRANCH, LOADUSE) used for debug/assertions.
- One natural sub-module: hazard_detect, a purely combinational load-use comparator (inputs id_rs/id_rt/uses/ex_memread/ex_rd, output load_use). The FSM, priority mux and counters stay in the top.

Test Plan:
1. Load-use: ex_memread=1, ex_rd=8, id_rs=8, id_uses_rs=1 for one cycle. Required: en_pc=en_ifid=0, flush_idex=1, stall_cnt 0->1. Next cycle all en=1.
2. r0 and unused operand:
   - ex_rd=0, id_rs=0, uses_rs=1 -> no stall.
   - ex_rd=5, id_rt=5, uses_rt=0 -> no stall.
3. Branch over load-use: branch_taken=1 together with a load-use match. Required: flush_ifid=flush_idex=1, en_pc=1, stall_cnt unchanged.
4. Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1. Required: all en=0 for 3 cycles, state MEM_WAIT, stall_cnt +=3, back to RUN and all en=1 on the ready cycle.
5. Timeout with MEM_TIMEOUT=4: mem_req=1, mem_ready=0 held. Required: enables low for 3 cycles, released on the 4th cycle, mem_err pulses exactly 1 cycle, state RUN.
6. Reset mid-MEM_WAIT: assert rst for 1 cycle. Required: during rst all en=0 and flush=1. After rst: state RUN, stall_cnt=0, mem_err=0.
